// File: rtl/screen_scanout.sv
`default_nettype none
// ------------------------------------------------------------------------
// screen_scanout : screen memory read sequencer -> gapless 1-bit pixel stream
// Rev 1.0
// ------------------------------------------------------------------------
module screen_scanout #(
  parameter int COLS_WORDS = 32,
  parameter int ROWS       = 256,
  parameter bit INVERT     = 1'b0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [12:0] r_address,
  input  logic [15:0] qb,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        frame_done
);

  localparam int          c_words     = COLS_WORDS * ROWS;
  localparam logic [12:0] c_last_addr = 13'(c_words - 1);
  localparam logic [8:0]  c_last_x    = 9'(COLS_WORDS * 16 - 1);
  localparam logic [7:0]  c_last_y    = 8'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME0 = 2'd1,
    S_PRIME1 = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_shreg;
  logic [15:0] r_prefetch;
  logic        r_pre_full;
  logic [3:0]  r_bit_cnt;

  logic        w_hs;
  logic        w_last_px;
  logic [12:0] w_addr_next;

  assign w_hs        = pix_valid & pix_ready & (r_state == S_STREAM);
  assign w_last_px   = (pix_x == c_last_x) && (pix_y == c_last_y);
  // Address saturates at the last word so a trailing refill just re-reads it
  assign w_addr_next = (r_address == c_last_addr) ? r_address : r_address + 13'd1;

  assign pix  = pix_valid & (r_shreg[0] ^ INVERT);
  assign sof  = pix_valid && (pix_x == 9'd0) && (pix_y == 8'd0);
  assign eol  = pix_valid && (pix_x == c_last_x);
  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_PRIME0;
      S_PRIME0: w_next_state = S_PRIME1;
      S_PRIME1: w_next_state = S_STREAM;
      S_STREAM: if (w_hs && w_last_px) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_address  <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      r_shreg    <= '0;
      r_prefetch <= '0;
      r_pre_full <= 1'b0;
      r_bit_cnt  <= '0;
    end else if (abort) begin
      r_address  <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      r_pre_full <= 1'b0;
      r_bit_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_address <= '0;
          pix_valid <= 1'b0;
        end
        S_PRIME0: begin
          r_shreg   <= qb;
          r_address <= w_addr_next;
        end
        S_PRIME1: begin
          if (c_words > 1) begin
            r_prefetch <= qb;
            r_pre_full <= 1'b1;
            r_address  <= w_addr_next;
          end
          pix_valid <= 1'b1;
        end
        S_STREAM: begin
          // Refill runs the cycle after a word swap; the handshake block below wins on overlap
          if (!r_pre_full && (c_words > 1)) begin
            r_prefetch <= qb;
            r_pre_full <= 1'b1;
            r_address  <= w_addr_next;
          end
          if (w_hs) begin
            if (w_last_px) begin
              pix_valid  <= 1'b0;
              frame_done <= 1'b1;
              r_address  <= '0;
              pix_x      <= '0;
              pix_y      <= '0;
              r_bit_cnt  <= '0;
              r_pre_full <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (pix_x == c_last_x) begin
                pix_x <= '0;
                pix_y <= pix_y + 8'd1;
              end else begin
                pix_x <= pix_x + 9'd1;
              end
              if (r_bit_cnt == 4'hF) begin
                r_shreg    <= r_prefetch;
                r_pre_full <= 1'b0;
              end else begin
                r_shreg <= {1'b0, r_shreg[15:1]};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_screen_scanout.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_screen_scanout : scoreboard bench for screen_scanout
// Rev 1.0
// ------------------------------------------------------------------------
module tb_screen_scanout;

  localparam int COLS = 4;
  localparam int ROWS = 8;
  localparam int NW   = COLS * ROWS;
  localparam int WPX  = COLS * 16;
  localparam bit INV  = 1'b0;

  logic        clock = 1'b0;
  logic        rst_n, start, abort, pix_ready;
  logic [12:0] r_address;
  logic [15:0] qb;
  logic        pix, pix_valid, sof, eol, busy, frame_done;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;

  logic        start2, abort2, pix_ready2;
  logic [12:0] r_address2;
  logic [15:0] qb2;
  logic        pix2, pix_valid2, sof2, eol2, busy2, frame_done2;
  logic [8:0]  pix_x2;
  logic [7:0]  pix_y2;

  logic [15:0] mem  [0:8191];
  logic [15:0] mem2 [0:1];

  always #5 clock = ~clock;

  assign qb  = mem[r_address];
  assign qb2 = mem2[r_address2[0]];

  screen_scanout #(.COLS_WORDS(COLS), .ROWS(ROWS), .INVERT(INV)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .r_address(r_address), .qb(qb), .pix(pix), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol),
    .busy(busy), .frame_done(frame_done)
  );

  screen_scanout #(.COLS_WORDS(1), .ROWS(2), .INVERT(1'b1)) dut2 (
    .clock(clock), .rst_n(rst_n), .start(start2), .abort(abort2),
    .r_address(r_address2), .qb(qb2), .pix(pix2), .pix_valid(pix_valid2),
    .pix_ready(pix_ready2), .pix_x(pix_x2), .pix_y(pix_y2), .sof(sof2), .eol(eol2),
    .busy(busy2), .frame_done(frame_done2)
  );

  typedef struct {
    logic       p;
    logic [8:0] x;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   gapless, seen_valid, exp_done, rand_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < WPX; x++) begin
        exp_t e;
        int   w;
        w   = y * COLS + x / 16;
        e.p = mem[w][x % 16] ^ INV;
        e.x = 9'(x);
        e.y = 8'(y);
        sb.push_back(e);
      end
    end
  endtask

  // Outputs are sampled at the falling edge; pix_ready is already the value the next rising edge will see
  task automatic monitor();
    exp_t e;
    check_val("frame_done", frame_done, exp_done);
    exp_done = 1'b0;
    check_val("addr_range", r_address <= 13'(NW - 1), 1);
    if (sb.size() == 0) begin
      check_val("idle_valid", pix_valid, 0);
    end else if (pix_valid) begin
      e = sb[0];
      check_val("pix", pix, e.p);
      check_val("pix_x", pix_x, e.x);
      check_val("pix_y", pix_y, e.y);
      check_val("sof", sof, (e.x == 9'd0) && (e.y == 8'd0));
      check_val("eol", eol, e.x == 9'(WPX - 1));
      seen_valid = 1'b1;
      if (pix_ready) begin
        void'(sb.pop_front());
        if (sb.size() == 0) exp_done = 1'b1;
      end
    end else if (gapless && seen_valid) begin
      check_val("gap", pix_valid, 1);
    end
  endtask

  task automatic step();
    @(negedge clock);
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    monitor();
  endtask

  task automatic kick_frame(input bit rnd, input bit gap);
    rand_ready = rnd;
    gapless    = gap;
    seen_valid = 1'b0;
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input bit gap);
    kick_frame(rnd, gap);
    check_val("prime0_valid", pix_valid, 0);
    check_val("prime0_busy", busy, 1);
    step();
    check_val("prime1_valid", pix_valid, 0);
    step();
    check_val("stream_valid", pix_valid, 1);
    for (int i = 0; i < 4000 && sb.size() > 0; i++) step();
    check_val("frame_timeout", sb.size(), 0);
    sb.delete();
    step();
    check_val("end_addr", r_address, 0);
    check_val("end_busy", busy, 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; pix_ready2 = 1'b1;
    rand_ready = 1'b0; gapless = 1'b0; seen_valid = 1'b0; exp_done = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    mem2[0] = 16'h0000;
    mem2[1] = 16'h0000;

    repeat (3) @(negedge clock);
    check_val("rst_addr", r_address, 0);
    check_val("rst_valid", pix_valid, 0);
    check_val("rst_pix", pix, 0);
    check_val("rst_xy", {pix_x, pix_y}, 0);
    check_val("rst_flags", {sof, eol, busy, frame_done}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Address-pattern frame, always ready
    run_frame(1'b0, 1'b1);
    // Same frame under random backpressure
    run_frame(1'b1, 1'b0);

    // Edge-bit pattern
    for (int w = 0; w < NW; w++) mem[w] = 16'h8001;
    run_frame(1'b1, 1'b0);
    for (int w = 0; w < NW; w++) mem[w] = 16'(w);

    // Abort mid-frame on an accepted pixel
    kick_frame(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (pix_valid && pix_x == 9'd40 && pix_y == 8'd5) begin
        found = 1'b1;
        break;
      end
    end
    check_val("abort_reach", found, 1);
    abort = 1'b1;
    sb.delete();
    exp_done = 1'b0;
    seen_valid = 1'b0;
    step();
    abort = 1'b0;
    check_val("abort_valid", pix_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", frame_done, 0);
    check_val("abort_addr", r_address, 0);
    // Abort in idle beats start
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check_val("abort_idle_busy", busy, 0);
    run_frame(1'b0, 1'b1);

    // Asynchronous reset mid-stream
    kick_frame(1'b0, 1'b1);
    repeat (100) step();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", pix_valid, 0);
    check_val("arst_pix", pix, 0);
    check_val("arst_addr", r_address, 0);
    check_val("arst_xy", {pix_x, pix_y}, 0);
    check_val("arst_flags", {sof, eol, busy, frame_done}, 0);
    sb.delete();
    exp_done = 1'b0;
    seen_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("post_rst_busy", busy, 0);
    end

    // Inverted 1x2 geometry, memory all zero
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pix_valid2 && pix_ready2) begin
        check_val("inv_pix", pix2, 1);
        cnt++;
      end
      check_val("inv_addr", r_address2 <= 13'd1, 1);
      if (frame_done2) begin
        found = 1'b1;
        break;
      end
    end
    check_val("inv_done", found, 1);
    check_val("inv_count", cnt, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
